multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the processor datapath: the block that fills the control-unit slot between instruction memory and the datapath. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath strobes:
- PC advance
- register write
- ALU operand select
- data-memory read/write with ready handshake
- stack push/pop
- write-back mux select

It also counts retired instructions and halts on HALT, illegal opcode or stack underflow.

---
 rtl/multicycle_ctrl_pkg.sv | 39 +++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl_opclass_decode.sv | 25 ++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer and datapath units.
package multicycle_ctrl_pkg;

  localparam int unsigned OPW  = 6;
  localparam int unsigned CNTW = 32;

  localparam logic [OPW-1:0] OP_ALU_R = OPW'('h00);
  localparam logic [OPW-1:0] OP_ALU_I = OPW'('h01);
  localparam logic [OPW-1:0] OP_LD    = OPW'('h02);
  localparam logic [OPW-1:0] OP_ST    = OPW'('h03);
  localparam logic [OPW-1:0] OP_BR    = OPW'('h04);
  localparam logic [OPW-1:0] OP_PUSH  = OPW'('h08);
  localparam logic [OPW-1:0] OP_POP   = OPW'('h09);
  localparam logic [OPW-1:0] OP_HALT  = OPW'('h3F);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_STACK, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_ALUI, C_LD, C_ST, C_BR, C_PUSH, C_POP, C_HALT, C_ILL
  } opclass_e;

  typedef struct packed {
    logic ir_load;
    logic pc_en;
    logic branch_en;
    logic alu_src_imm;
    logic mem_read;
    logic mem_write;
    logic stk_push;
    logic stk_pop;
    logic reg_write;
    logic wb_sel;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '0;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/status inputs and control strobes.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [OPW-1:0]  opcode;
  logic            mem_ready;
  logic            stk_empty;
  logic            ir_load;
  logic            pc_en;
  logic            branch_en;
  logic            alu_src_imm;
  logic            mem_read;
  logic            mem_write;
  logic            stk_push;
  logic            stk_pop;
  logic            reg_write;
  logic            wb_sel;
  logic            halted;
  logic            illegal;
  logic [CNTW-1:0] retired;

  modport master (
    input  opcode, mem_ready, stk_empty,
    output ir_load, pc_en, branch_en, alu_src_imm, mem_read, mem_write,
           stk_push, stk_pop, reg_write, wb_sel, halted, illegal, retired
  );

  modport slave (
    output opcode, mem_ready, stk_empty,
    input  ir_load, pc_en, branch_en, alu_src_imm, mem_read, mem_write,
           stk_push, stk_pop, reg_write, wb_sel, halted, illegal, retired
  );

endinterface

// File: rtl/multicycle_ctrl_opclass_decode.sv
// Opcode to instruction-class lookup; anything unlisted is illegal.
module opclass_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output opclass_e       opclass_c
);

  // map opcode field to class
  always_comb begin
    opclass_c = C_ILL;
    case (opcode)
      OP_ALU_R: opclass_c = C_ALU;
      OP_ALU_I: opclass_c = C_ALUI;
      OP_LD:    opclass_c = C_LD;
      OP_ST:    opclass_c = C_ST;
      OP_BR:    opclass_c = C_BR;
      OP_PUSH:  opclass_c = C_PUSH;
      OP_POP:   opclass_c = C_POP;
      OP_HALT:  opclass_c = C_HALT;
      default:  opclass_c = C_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/STACK/WB/HALT walk,
// datapath strobes and retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  state_e          state_q, state_d;
  opclass_e        cls_q, cls_d, dec_cls_c;
  logic            pop_ok_q, pop_ok_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  strobes_t        str_q, str_d;
  logic [CNTW-1:0] retired_q;
  logic            st_done_c;
  logic            pc_en_c;

  opclass_decode u_opclass_decode (
    .opcode    (bus.opcode),
    .opclass_c (dec_cls_c)
  );

  // next state, latched class, stack-empty sample and sticky flags
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    pop_ok_d  = pop_ok_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        cls_d = dec_cls_c;
        // stack flag is stable here: the last push/pop strobe was >= 2 cycles ago
        pop_ok_d = !bus.stk_empty;
        case (dec_cls_c)
          C_PUSH, C_POP: state_d = S_STACK;
          C_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          C_ILL: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_LD, C_ST: state_d = S_MEM;
          C_BR:       state_d = S_FETCH;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
        end
      end
      S_STACK: begin
        if (cls_q != C_POP) begin
          state_d = S_FETCH;
        end else if (pop_ok_q) begin
          state_d = S_WB;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // strobes for the state being entered, so they register in step with it
  always_comb begin
    str_d = STROBES_IDLE;
    case (state_d)
      S_DECODE: str_d.ir_load = 1'b1;
      S_EXEC: begin
        str_d.alu_src_imm = cls_d inside {C_ALUI, C_LD, C_ST};
        str_d.branch_en   = (cls_d == C_BR);
        str_d.pc_en       = (cls_d == C_BR);
      end
      S_MEM: begin
        str_d.mem_read  = (cls_d == C_LD);
        str_d.mem_write = (cls_d == C_ST);
      end
      S_STACK: begin
        str_d.stk_push = (cls_d == C_PUSH);
        str_d.pc_en    = (cls_d == C_PUSH);
        str_d.stk_pop  = (cls_d == C_POP) && pop_ok_d;
      end
      S_WB: begin
        str_d.reg_write = 1'b1;
        str_d.pc_en     = 1'b1;
        str_d.wb_sel    = cls_d inside {C_LD, C_POP};
      end
      default: str_d = STROBES_IDLE;
    endcase
  end

  // state, class and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ILL;
      pop_ok_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      str_q     <= STROBES_IDLE;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      pop_ok_q  <= pop_ok_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      str_q     <= str_d;
    end
  end

  // a store retires in whichever MEM cycle sees mem_ready
  assign st_done_c = (state_q == S_MEM) && (cls_q == C_ST) && bus.mem_ready;
  assign pc_en_c   = str_q.pc_en | st_done_c;

  // retired-instruction counter, one per pc_en, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else if (pc_en_c) begin
      retired_q <= retired_q + CNTW'(1);
    end
  end

  assign bus.ir_load     = str_q.ir_load;
  assign bus.pc_en       = pc_en_c;
  assign bus.branch_en   = str_q.branch_en;
  assign bus.alu_src_imm = str_q.alu_src_imm;
  assign bus.mem_read    = str_q.mem_read;
  assign bus.mem_write   = str_q.mem_write;
  assign bus.stk_push    = str_q.stk_push;
  assign bus.stk_pop     = str_q.stk_pop;
  assign bus.reg_write   = str_q.reg_write;
  assign bus.wb_sel      = str_q.wb_sel;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus reset/halt sequences.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  // strobe bit positions: ir_load pc_en branch_en alu_src_imm mem_read mem_write push pop reg_write wb_sel
  localparam logic [9:0] Z   = 10'b00_0000_0000;
  localparam logic [9:0] IR  = 10'b10_0000_0000;
  localparam logic [9:0] PC  = 10'b01_0000_0000;
  localparam logic [9:0] BR  = 10'b00_1000_0000;
  localparam logic [9:0] IMM = 10'b00_0100_0000;
  localparam logic [9:0] RD  = 10'b00_0010_0000;
  localparam logic [9:0] WR  = 10'b00_0001_0000;
  localparam logic [9:0] PU  = 10'b00_0000_1000;
  localparam logic [9:0] PO  = 10'b00_0000_0100;
  localparam logic [9:0] RW  = 10'b00_0000_0010;
  localparam logic [9:0] WS  = 10'b00_0000_0001;

  typedef struct {
    logic [OPW-1:0]  op;
    logic            rdy;
    logic            emp;
    logic [9:0]      str;
    logic            halted;
    logic            illegal;
    logic [CNTW-1:0] ret;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  vec_t vecs[$];

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(logic [OPW-1:0] op, logic rdy, logic emp, logic [9:0] str,
                              logic h, logic il, logic [CNTW-1:0] ret);
    vec_t v;
    v.op = op; v.rdy = rdy; v.emp = emp; v.str = str;
    v.halted = h; v.illegal = il; v.ret = ret;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic [9:0] str, logic h, logic il, logic [CNTW-1:0] ret);
    logic [9:0] act;
    act = {bus.ir_load, bus.pc_en, bus.branch_en, bus.alu_src_imm, bus.mem_read,
           bus.mem_write, bus.stk_push, bus.stk_pop, bus.reg_write, bus.wb_sel};
    total++;
    if (act !== str || bus.halted !== h || bus.illegal !== il || bus.retired !== ret) begin
      $display("FAIL %s: got strobes=%b halted=%b illegal=%b retired=%0d, want strobes=%b halted=%b illegal=%b retired=%0d",
               n, act, bus.halted, bus.illegal, bus.retired, str, h, il, ret);
    end else begin
      passed++;
    end
  endtask

  // one cycle: drive inputs after negedge, check current-state outputs, advance past posedge
  task automatic cyc(string n, logic [OPW-1:0] op, logic rdy, logic emp, logic [9:0] str,
                     logic h, logic il, logic [CNTW-1:0] ret);
    bus.opcode = op; bus.mem_ready = rdy; bus.stk_empty = emp;
    #1;
    check(n, str, h, il, ret);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.stk_empty = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset", Z, 1'b0, 1'b0, '0);
    rst = 1'b1;
  endtask

  initial begin
    logic [OPW-1:0] ill_ops[4];
    total  = 0;
    passed = 0;
    rst    = 1'b0;
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.stk_empty = 1'b0;

    // ALU_R
    add(6'h00, 0, 0, Z,       0, 0, 0);
    add(6'h00, 0, 0, IR,      0, 0, 0);
    add(6'h00, 0, 0, Z,       0, 0, 0);
    add(6'h00, 0, 0, PC|RW,   0, 0, 0);
    // ALU_I
    add(6'h01, 0, 0, Z,       0, 0, 1);
    add(6'h01, 0, 0, IR,      0, 0, 1);
    add(6'h01, 0, 0, IMM,     0, 0, 1);
    add(6'h01, 0, 0, PC|RW,   0, 0, 1);
    // LD with three wait cycles
    add(6'h02, 0, 0, Z,       0, 0, 2);
    add(6'h02, 0, 0, IR,      0, 0, 2);
    add(6'h02, 0, 0, IMM,     0, 0, 2);
    add(6'h02, 0, 0, RD,      0, 0, 2);
    add(6'h02, 0, 0, RD,      0, 0, 2);
    add(6'h02, 0, 0, RD,      0, 0, 2);
    add(6'h02, 1, 0, RD,      0, 0, 2);
    add(6'h02, 0, 0, PC|RW|WS,0, 0, 2);
    // ST with one wait cycle
    add(6'h03, 0, 0, Z,       0, 0, 3);
    add(6'h03, 0, 0, IR,      0, 0, 3);
    add(6'h03, 0, 0, IMM,     0, 0, 3);
    add(6'h03, 0, 0, WR,      0, 0, 3);
    add(6'h03, 1, 0, WR|PC,   0, 0, 3);
    // ST with mem_ready already high (ignored before MEM)
    add(6'h03, 1, 0, Z,       0, 0, 4);
    add(6'h03, 1, 0, IR,      0, 0, 4);
    add(6'h03, 1, 0, IMM,     0, 0, 4);
    add(6'h03, 1, 0, WR|PC,   0, 0, 4);
    // BR
    add(6'h04, 0, 0, Z,       0, 0, 5);
    add(6'h04, 0, 0, IR,      0, 0, 5);
    add(6'h04, 0, 0, BR|PC,   0, 0, 5);
    // PUSH
    add(6'h08, 0, 0, Z,       0, 0, 6);
    add(6'h08, 0, 0, IR,      0, 0, 6);
    add(6'h08, 0, 0, PU|PC,   0, 0, 6);
    // POP, stack not empty
    add(6'h09, 0, 0, Z,       0, 0, 7);
    add(6'h09, 0, 0, IR,      0, 0, 7);
    add(6'h09, 0, 0, PO,      0, 0, 7);
    add(6'h09, 0, 0, PC|RW|WS,0, 0, 7);
    // POP, stack empty -> illegal halt
    add(6'h09, 0, 1, Z,       0, 0, 8);
    add(6'h09, 0, 1, IR,      0, 0, 8);
    add(6'h09, 0, 1, Z,       0, 0, 8);
    add(6'h09, 0, 1, Z,       0, 1, 8);
    add(6'h00, 1, 0, Z,       0, 1, 8);
    add(6'h08, 1, 0, Z,       0, 1, 8);

    reset_dut();
    foreach (vecs[i]) begin
      cyc($sformatf("vec%0d", i), vecs[i].op, vecs[i].rdy, vecs[i].emp, vecs[i].str,
          vecs[i].halted, vecs[i].illegal, vecs[i].ret);
    end

    // HALT opcode: absorbing, no strobes whatever the inputs
    reset_dut();
    cyc("halt_fetch",  6'h3F, 0, 0, Z,  0, 0, 0);
    cyc("halt_decode", 6'h3F, 0, 0, IR, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc("halt_idle", OPW'($urandom_range(63, 0)), 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), Z, 1, 0, 0);
    end

    // unlisted opcodes, including neighbours of legal ones
    ill_ops[0] = 6'h15; ill_ops[1] = 6'h05; ill_ops[2] = 6'h0A; ill_ops[3] = 6'h3E;
    foreach (ill_ops[k]) begin
      reset_dut();
      cyc("ill_fetch",  ill_ops[k], 0, 0, Z,  0, 0, 0);
      cyc("ill_decode", ill_ops[k], 0, 0, IR, 0, 0, 0);
      cyc("ill_halt",   ill_ops[k], 0, 0, Z,  0, 1, 0);
      cyc("ill_stay",   6'h00,      1, 0, Z,  0, 1, 0);
    end

    // reset asserted mid-MEM drops mem_read immediately and clears retired
    reset_dut();
    cyc("pre_fetch",  6'h00, 0, 0, Z,     0, 0, 0);
    cyc("pre_decode", 6'h00, 0, 0, IR,    0, 0, 0);
    cyc("pre_exec",   6'h00, 0, 0, Z,     0, 0, 0);
    cyc("pre_wb",     6'h00, 0, 0, PC|RW, 0, 0, 0);
    cyc("ld_fetch",   6'h02, 0, 0, Z,     0, 0, 1);
    cyc("ld_decode",  6'h02, 0, 0, IR,    0, 0, 1);
    cyc("ld_exec",    6'h02, 0, 0, IMM,   0, 0, 1);
    bus.mem_ready = 1'b0;
    #1;
    check("ld_mem", RD, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_mem", Z, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc("post_fetch",  6'h00, 0, 0, Z,  0, 0, 0);
    cyc("post_decode", 6'h00, 0, 0, IR, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
